// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with runtime frame format and baud selection.
//
// Parameters:
//   ClkFreqHz   system clock frequency in Hz; bit-period divisors derive from it
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   cfg_i       frame config {data_bits-5 [4:3], stop_bits-1 [2:1], parity_en [0]}
//   baud_sel_i  00=9600, 01=19200, 10=115200, 11=256000
//   data_i      byte to send, LSB first; bits above the data width are ignored
//   valid_i     data_i/cfg_i/baud_sel_i valid; accepted when ready_o is high
//   ready_o     transmitter idle and able to accept a byte
//   tx_o        serial line, idle high
//   busy_o      frame in progress
//   done_o      one-cycle pulse in the last cycle of the final stop bit
//
// Build option:
//   FPGA_UART_TX_PARITY_EN  when defined, cfg_i[0] enables an even parity bit.
//                           When undefined, cfg_i[0] is ignored and no parity
//                           state or logic is built.

module uart_tx #(
  parameter int unsigned ClkFreqHz = 100000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] cfg_i,
  input  logic [1:0] baud_sel_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  // Rounded divisors: (f + baud/2) / baud.
  localparam int unsigned Div0 = (ClkFreqHz + 4800) / 9600;
  localparam int unsigned Div1 = (ClkFreqHz + 9600) / 19200;
  localparam int unsigned Div2 = (ClkFreqHz + 57600) / 115200;
  localparam int unsigned Div3 = (ClkFreqHz + 128000) / 256000;

  if (Div0 > 65535 || Div1 > 65535 || Div2 > 65535 || Div3 > 65535 ||
      Div0 < 2 || Div1 < 2 || Div2 < 2 || Div3 < 2) begin : gen_bad_div
    $error("uart_tx: baud divisor does not fit the 16-bit bit-period counter");
  end

`ifdef FPGA_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  stop_q, stop_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  nbits_q, nbits_d;
  logic [1:0]  nstop_q, nstop_d;
  logic [1:0]  baud_q, baud_d;
  logic        init_q;

`ifdef FPGA_UART_TX_PARITY_EN
  logic        par_en_q, par_en_d;
  logic        par_q, par_d;
  logic [7:0]  data_mask;
`else
  logic        unused_cfg;
  assign unused_cfg = cfg_i[0];
`endif

  logic [15:0] div;
  logic        bit_end;
  logic [1:0]  stop_last;
  logic        last_stop;
  logic        last_data;
  logic        accept;

  always_comb begin
    unique case (baud_q)
      2'b00:   div = 16'(Div0);
      2'b01:   div = 16'(Div1);
      2'b10:   div = 16'(Div2);
      default: div = 16'(Div3);
    endcase
  end

  assign bit_end   = (cnt_q == div - 16'd1);
  // Stop code 3 is treated as 3 stop bits, same as code 2.
  assign stop_last = (nstop_q == 2'd3) ? 2'd2 : nstop_q;
  assign last_stop = (stop_q == stop_last);
  assign last_data = (bit_q == ({1'b0, nbits_q} + 3'd4));

  // init_q holds ready_o low until the first edge after reset release.
  assign ready_o = init_q && (state_q == StIdle);
  assign busy_o  = (state_q != StIdle);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    nbits_d = nbits_q;
    nstop_d = nstop_q;
    baud_d  = baud_q;
    done_o  = 1'b0;
`ifdef FPGA_UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_d     = par_q;
    // Keep only the configured data bits so parity ignores the unsent ones.
    data_mask = 8'hFF >> (2'd3 - cfg_i[4:3]);
`endif

    if (state_q != StIdle) begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          cnt_d   = 16'd0;
          shift_d = data_i;
          nbits_d = cfg_i[4:3];
          nstop_d = cfg_i[2:1];
          baud_d  = baud_sel_i;
`ifdef FPGA_UART_TX_PARITY_EN
          par_en_d = cfg_i[0];
          par_d    = ^(data_i & data_mask);
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (last_data) begin
            stop_d = 2'd0;
`ifdef FPGA_UART_TX_PARITY_EN
            state_d = par_en_q ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef FPGA_UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          stop_d  = 2'd0;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = StIdle;
            done_o  = 1'b1;
          end else begin
            stop_d = stop_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      StStart:  tx_o = 1'b0;
      StData:   tx_o = shift_q[0];
`ifdef FPGA_UART_TX_PARITY_EN
      StParity: tx_o = par_q;
`endif
      default:  tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      stop_q  <= 2'd0;
      shift_q <= 8'd0;
      nbits_q <= 2'd0;
      nstop_q <= 2'd0;
      baud_q  <= 2'd0;
      init_q  <= 1'b0;
`ifdef FPGA_UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      nbits_q <= nbits_d;
      nstop_q <= nstop_d;
      baud_q  <= baud_d;
      init_q  <= 1'b1;
`ifdef FPGA_UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

endmodule
